// File: rtl/tb_exit_monitor_pkg.sv
// Shared types and register offsets for the exit monitor:
// run outcome encoding, monitor FSM states and the APB register map.
package pkg_exit_status;

    typedef enum logic [1:0] {
        RUNNING = 2'd0,
        SUCCESS = 2'd1,
        FAILURE = 2'd2,
        TIMEOUT = 2'd3
    } exit_status_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } exit_mon_state_e;

    localparam logic [11:0] EXIT_OFS = 12'h000;
    localparam logic [11:0] KICK_OFS = 12'h004;
    localparam logic [11:0] STAT_OFS = 12'h008;

endpackage

// File: rtl/tb_exit_monitor_if.sv
// APB bus bundle between the chip-side master and the exit monitor slave.
interface tb_exit_monitor_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/tb_exit_monitor_watchdog.sv
// Saturating watchdog counter: counts while enabled, clears on a kick and
// flags expiry on the edge the count would reach LIMIT (LIMIT=0 disables it).
module tb_exit_watchdog #(
    parameter int unsigned LIMIT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        clr_i,
    output logic        expire_o,
    output logic [31:0] count_o
);
    localparam int unsigned CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A kick beats a simultaneous increment; the counter holds at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    generate
        if (LIMIT == 0) begin : g_disabled
            assign expire_o = 1'b0;
        end else begin : g_enabled
            assign expire_o = en_i && !clr_i && (count_q == LAST);
        end
    endgenerate

    assign count_o = 32'(count_q);
endmodule

// File: rtl/tb_exit_monitor.sv
// APB-mapped exit monitor: latches the software exit code or a watchdog
// timeout, optionally drains for a few cycles, then raises done/status.
module tb_exit_monitor
    import pkg_exit_status::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h1A10_F000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned DRAIN_CYCLES   = 16
) (
    input  logic               clk,
    input  logic               rst,
    tb_exit_monitor_if.slave   apb,
    output logic               done,
    output exit_status_e       status,
    output logic [31:0]        exit_code,
    output logic [31:0]        run_cycles
);
    localparam int unsigned DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);

    exit_mon_state_e state_q, state_d;
    exit_status_e    status_q, status_d;
    logic [31:0]     exit_code_q, exit_code_d;
    logic [31:0]     run_cycles_q, run_cycles_d;
    logic [DW-1:0]   drain_q, drain_d;

    logic        in_window, access, in_run;
    logic [11:0] ofs;
    logic        wr_exit, wr_kick;
    logic        wd_expire;
    logic [31:0] wd_count;

    assign in_window = (apb.paddr[31:12] == BASE_ADDR[31:12]);
    assign access    = apb.psel && apb.penable && in_window;
    assign ofs       = apb.paddr[11:0];
    assign in_run    = (state_q == ST_RUN);
    assign wr_exit   = access && apb.pwrite && (ofs == EXIT_OFS) && in_run;
    assign wr_kick   = access && apb.pwrite && (ofs == KICK_OFS) && in_run;

    tb_exit_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .en_i     (in_run),
        .clr_i    (wr_kick),
        .expire_o (wd_expire),
        .count_o  (wd_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            status_q     <= RUNNING;
            exit_code_q  <= '0;
            run_cycles_q <= '0;
            drain_q      <= '0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            exit_code_q  <= exit_code_d;
            run_cycles_q <= run_cycles_d;
            drain_q      <= drain_d;
        end
    end

    // EXIT is checked before expiry so a same-cycle exit write wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (wr_exit) begin
                    state_d = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
                end else if (wd_expire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        status_d     = status_q;
        exit_code_d  = exit_code_q;
        run_cycles_d = run_cycles_q;
        drain_d      = drain_q;
        case (state_q)
            ST_RUN: begin
                if (run_cycles_q != '1) begin
                    run_cycles_d = run_cycles_q + 32'd1;
                end
                if (wr_exit) begin
                    exit_code_d = apb.pwdata;
                    status_d    = (apb.pwdata == '0) ? SUCCESS : FAILURE;
                    drain_d     = DRAIN_LOAD;
                end else if (wd_expire) begin
                    status_d = TIMEOUT;
                end
            end
            ST_DRAIN: begin
                if (drain_q != '0) begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        done       = (state_q == ST_DONE);
        status     = status_q;
        exit_code  = exit_code_q;
        run_cycles = run_cycles_q;
    end

    // Read data and error are combinational on the access phase.
    always_comb begin
        apb.prdata  = '0;
        apb.pslverr = 1'b0;
        apb.pready  = 1'b1;
        if (access) begin
            case (ofs)
                EXIT_OFS: apb.prdata = apb.pwrite ? 32'd0 : exit_code_q;
                KICK_OFS: apb.prdata = apb.pwrite ? 32'd0 : wd_count;
                STAT_OFS: apb.prdata = apb.pwrite ? 32'd0 : {29'd0, done, status_q};
                default:  apb.pslverr = 1'b1;
            endcase
        end
    end
endmodule
